// File: rtl/down_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : down_chk_pkg
// Description : Shared state encoding and default sizes for down_count_checker.
// Revision    : 1.0 - initial release
// ============================================================================
package down_chk_pkg;

    localparam int DOWN_CHK_WIDTH  = 4;
    localparam int DOWN_CHK_WRAP_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } down_chk_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that increments on inc and sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic         w_full;

    assign w_full = &r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && !w_full) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/down_count_checker.sv
`default_nettype none
// ============================================================================
// Module      : down_count_checker
// Description : Locks onto a down-counter sequence and flags any sample that is
//               not exactly one below the previous one. Fault recovery is
//               selected by the DOWN_CHK_RESYNC_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module down_count_checker
    import down_chk_pkg::*;
#(
    parameter int WIDTH  = DOWN_CHK_WIDTH,
    parameter int WRAP_W = DOWN_CHK_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  cnt_in,
    output logic              locked,
    output logic              err,
    output logic              tc_pulse,
    output logic [WRAP_W-1:0] wraps,
    output logic [WIDTH-1:0]  last_bad
);

    down_chk_state_t r_state, w_state_nxt;
    logic [WIDTH-1:0] r_prev, w_prev_nxt;
    logic [WIDTH-1:0] r_last_bad, w_last_bad_nxt;
    logic             r_tc, w_tc_nxt;
    logic             r_locked, r_err;
    logic             w_wrap_inc;
    logic [WIDTH-1:0] w_exp;

    assign w_exp = r_prev - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            r_last_bad <= '0;
            r_tc       <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_last_bad <= w_last_bad_nxt;
            r_tc       <= w_tc_nxt;
            r_locked   <= (w_state_nxt == LOCKED);
            r_err      <= (w_state_nxt == FAULT);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev;
        w_last_bad_nxt = r_last_bad;
        w_tc_nxt       = 1'b0;
        w_wrap_inc     = 1'b0;
        if (en) begin
            case (r_state)
                IDLE: begin
                    w_prev_nxt  = cnt_in;
                    w_state_nxt = LOCKED;
                end
                LOCKED: begin
                    if (cnt_in == w_exp) begin
                        w_prev_nxt = cnt_in;
                        w_tc_nxt   = (cnt_in == '0);
                        w_wrap_inc = (r_prev == '0);
                    end else begin
                        w_last_bad_nxt = cnt_in;
                        w_state_nxt    = FAULT;
                    end
                end
                FAULT: begin
`ifdef DOWN_CHK_RESYNC_EN
                    // Relock on the first sample after a fault, unchecked.
                    w_prev_nxt  = cnt_in;
                    w_state_nxt = LOCKED;
`else
                    w_state_nxt = FAULT;
`endif
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W   (WRAP_W)
    ) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_wrap_inc),
        .q   (wraps)
    );

    assign locked   = r_locked;
    assign err      = r_err;
    assign tc_pulse = r_tc;
    assign last_bad = r_last_bad;

endmodule
`default_nettype wire

// File: tb/tb_down_count_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_count_checker
// Description : Directed table-driven bench for down_count_checker; expected
//               values follow DOWN_CHK_RESYNC_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_count_checker;

    localparam int WIDTH  = 4;
    localparam int WRAP_W = 2;
`ifdef DOWN_CHK_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              en;
    logic [WIDTH-1:0]  cnt_in;
    logic              locked;
    logic              err;
    logic              tc_pulse;
    logic [WRAP_W-1:0] wraps;
    logic [WIDTH-1:0]  last_bad;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic              rst;
        logic              en;
        logic [WIDTH-1:0]  cnt;
        logic              lk;
        logic              er;
        logic              tc;
        logic [WRAP_W-1:0] wr;
        logic [WIDTH-1:0]  lb;
    } vec_t;

    vec_t vq[$];

    down_count_checker #(
        .WIDTH    (WIDTH),
        .WRAP_W   (WRAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cnt_in   (cnt_in),
        .locked   (locked),
        .err      (err),
        .tc_pulse (tc_pulse),
        .wraps    (wraps),
        .last_bad (last_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic lk, input logic er,
                             input logic tc, input logic [WRAP_W-1:0] wr,
                             input logic [WIDTH-1:0] lb);
        chk({tag, ".locked"},   int'(locked),   int'(lk));
        chk({tag, ".err"},      int'(err),      int'(er));
        chk({tag, ".tc_pulse"}, int'(tc_pulse), int'(tc));
        chk({tag, ".wraps"},    int'(wraps),    int'(wr));
        chk({tag, ".last_bad"}, int'(last_bad), int'(lb));
    endtask

    task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] c);
        rst    = r;
        en     = e;
        cnt_in = c;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic e, input int c,
                                input logic lk, input logic er, input logic tc,
                                input int wr, input int lb);
        vec_t v;
        v.rst = r;  v.en = e;  v.cnt = WIDTH'(c);
        v.lk  = lk; v.er = er; v.tc  = tc;
        v.wr  = WRAP_W'(wr);   v.lb  = WIDTH'(lb);
        vq.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; cnt_in = '0;

        // Reset, rst-with-en discarded, then a clean 15..0 run.
        add(1, 0, 0,  0, 0, 0, 0, 0);
        add(1, 1, 15, 0, 0, 0, 0, 0);
        add(0, 1, 15, 1, 0, 0, 0, 0);
        for (int v = 14; v >= 0; v--) add(0, 1, v, 1, 0, (v == 0), 0, 0);
        add(0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 1, 15, 1, 0, 0, 1, 0);
        add(0, 0, 3,  1, 0, 0, 1, 0);
        for (int v = 14; v >= 8; v--) add(0, 1, v, 1, 0, 0, 1, 0);
        // Skipped value, then recovery behaviour.
        add(0, 1, 6, 0, 1, 0, 1, 6);
        add(0, 1, 3, RESYNC, !RESYNC, 0, 1, 6);
        add(0, 1, 2, RESYNC, !RESYNC, 0, 1, 6);
        add(0, 1, 1, RESYNC, !RESYNC, 0, 1, 6);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].en, vq[i].cnt);
            check_all($sformatf("vec%0d", i), vq[i].lk, vq[i].er, vq[i].tc, vq[i].wr, vq[i].lb);
        end

        // Held value with en high on both samples faults.
        step(1, 0, 0);
        step(0, 1, 5);
        step(0, 1, 5);
        check_all("held", 0, 1, 0, 0, 5);

        // Same pattern with the second sample gated off does not.
        step(1, 0, 0);
        step(0, 1, 5);
        step(0, 0, 5);
        check_all("gated", 1, 0, 0, 0, 0);
        step(0, 1, 4);
        check_all("gated_next", 1, 0, 0, 0, 0);

        // Five full sequences against a 2-bit saturating wrap counter.
        step(1, 0, 0);
        step(0, 1, 15);
        for (int i = 1; i <= 80; i++) begin
            logic [WIDTH-1:0] c;
            c = WIDTH'(15 - (i % 16));
            step(0, 1, c);
            chk($sformatf("sat%0d.tc", i), int'(tc_pulse), int'(c == 0));
            if (i % 16 == 0)
                chk($sformatf("sat%0d.wraps", i), int'(wraps), (i / 16 > 3) ? 3 : i / 16);
        end
        chk("sat.err", int'(err), 0);

        // Asynchronous reset while locked mid-count.
        for (int v = 14; v >= 7; v--) step(0, 1, WIDTH'(v));
        check_all("pre_rst", 1, 0, 0, 3, 0);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0);
        step(0, 1, 12);
        check_all("relock", 1, 0, 0, 0, 0);
        step(0, 1, 11);
        check_all("relock_next", 1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
